optic_flow_accum_ci: RTL and testbench
======================================

Name: optic_flow_accum_ci

Overview:
- Multi-cycle custom-instruction successor to the combinational optic-flow CI.
- Takes binary-thresholded row segments of configurable width and derives per-column up/down/left/right motion masks.
- Returns per-call motion counts and keeps saturating accumulators for a whole frame.
- Sits on the processor custom-instruction bus. The CPU stalls on start until done.

Parameters:
- CUSTOM_ID, 8'd30, compute opcode. CUSTOM_ID+1 is the control opcode.
- SEG_W, 16, columns per segment. Legal values are 4, 8 and 16. Inputs are packed {upper, lower} in the low 2*SEG_W bits; unused high bits are ignored.
- CNT_W, 16, accumulator width. Legal range is 8..16.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  CI start strobe, 1 cycle.
- ciN  in  8  CI opcode.
- valueA  in  32  compute: {cur_up, cur_dn}. control: op select in [1:0].
- valueB  in  32  compute: {prev_up, prev_dn}.
- done  out  1  1-cycle completion pulse.
- result  out  32  valid only while done=1, otherwise 0.

Behaviour:
- Reset state:
  - done=0, result=0.
  - All accumulators = 0, busy = 0, pipeline valid bits = 0.
- Per-column masks (i in 0..SEG_W-1; a neighbour index outside 0..SEG_W-1 reads 0):
  - new_up[i] = cur_up[i] & ~prev_up[i]
  - up[i] = new_up[i] & prev_dn[i]
  - down[i] = cur_dn[i] & ~prev_dn[i] & prev_up[i]
  - left[i] = new_up[i] & prev_up[i+1]
  - right[i] = new_up[i] & prev_up[i-1]
- Compute op (start & ciN==CUSTOM_ID & !busy):
  - Cycle 0: latch operands, set busy.
  - Cycle 1 (stage 1): register the four masks.
  - Cycle 2 (stage 2): popcount each mask and pulse done.
  - result = {up_cnt[7:0], down_cnt[7:0], left_cnt[7:0], right_cnt[7:0]}.
  - Same cycle: each accumulator += its count, saturating at 2^CNT_W-1 (never wraps). Busy clears.
  - Latency: done asserts exactly 2 cycles after the start cycle.
- Control op (start & ciN==CUSTOM_ID+1 & !busy): done on the next cycle (latency 1). op=valueA[1:0]:
  - 0: result = {acc_up, acc_down}, each zero-extended to 16 bits.
  - 1: result = {acc_left, acc_right}, each zero-extended to 16 bits.
  - 2: result = 0. All accumulators clear at the done cycle.
  - 3: feature-dependent (see below).
- Start with any other ciN: ignored. done stays 0 and no state changes.
- Start while busy: ignored. No second done, no accumulator effect.
- Saturation: once an accumulator reaches max it holds max until a clear or reset.
- Reset mid-operation: the in-flight op is discarded. No done pulse, accumulators = 0, and a new start is accepted on the first cycle after reset deasserts.
- done is never high for two consecutive cycles from a single start.

Optional Feature:
- Macro: OPTIC_FLOW_DOMINANT_EN.
- With the macro defined, control op 3 returns result = {29'b0, valid, dir[1:0]}:
  - dir is the largest accumulator: 0=up, 1=down, 2=left, 3=right.
  - Ties resolve by priority up > down > left > right.
  - valid=0 and dir=0 when all accumulators are 0.
  - Comparison is registered; latency stays 1.
- Without the macro, op 3 returns 0 with latency 1 and no comparator logic is instantiated.

Test Plan:
- Default params; compute with valueA=32'h00010000, valueB=32'h00000001 -> done exactly 2 cycles after start, result=32'h01000000. Then control op0 -> 32'h00010000.
- Compute valueA=32'h00010000, valueB=32'h00020000 -> result=32'h00000100 (left=1; right=0 because of the boundary). Repeat with valueB=32'h00000000 -> result=0.
- Start with ciN=8'd47, then start during busy -> no done and no accumulator change. done stays 0 and result stays 0 throughout.
- CNT_W=8; issue 16 computes of valueA=32'hFFFF0000, valueB=32'h0000FFFF (each returns 32'h10000000) -> op0 returns 32'h00FF0000 (saturated at 255). Then op2 followed by op0 -> 32'h00000000.
- Assert reset in cycle 1 of a compute -> no done pulse, accumulators read 0, and the next compute is accepted normally.
- OPTIC_FLOW_DOMINANT_EN: after the left case twice and the up case once, op3 -> 32'h6 (valid=1, dir=left). After reset, op3 -> 32'h0. Without the macro, op3 always returns 32'h0.

Source files
------------

// File: rtl/optic_flow_accum_ci.sv
// Multi-cycle optic-flow custom instruction: per-call motion counts plus saturating per-frame accumulators.
// Compute done 2 cycles after start, control done after 1; starts while busy are dropped. Optional OPTIC_FLOW_DOMINANT_EN adds op 3.
module optic_flow_accum_ci #(
  parameter logic [7:0] CUSTOM_ID = 8'd30,
  parameter int         SEG_W     = 16,
  parameter int         CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [7:0] CTRL_ID = CUSTOM_ID + 8'd1;

  logic [SEG_W-1:0] cur_up, cur_dn, prev_up, prev_dn, new_up;
  logic [SEG_W-1:0] up_m, dn_m, lf_m, rt_m;
  logic [SEG_W-1:0] up_q, dn_q, lf_q, rt_q;
  logic             busy;
  logic [CNT_W-1:0] acc_up, acc_dn, acc_lf, acc_rt;
  logic [7:0]       up_cnt, dn_cnt, lf_cnt, rt_cnt;
  logic [31:0]      ctl_res;
  logic             unused_ok;

  function automatic logic [7:0] popcnt(input logic [SEG_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < SEG_W; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [7:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-7){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign cur_up  = valueA[2*SEG_W-1:SEG_W];
  assign cur_dn  = valueA[SEG_W-1:0];
  assign prev_up = valueB[2*SEG_W-1:SEG_W];
  assign prev_dn = valueB[SEG_W-1:0];
  assign unused_ok = ^{valueA, valueB};

  // Neighbour columns off the segment edge shift in as 0.
  assign new_up = cur_up & ~prev_up;
  assign up_m   = new_up & prev_dn;
  assign dn_m   = cur_dn & ~prev_dn & prev_up;
  assign lf_m   = new_up & (prev_up >> 1);
  assign rt_m   = new_up & (prev_up << 1);

  assign up_cnt = popcnt(up_q);
  assign dn_cnt = popcnt(dn_q);
  assign lf_cnt = popcnt(lf_q);
  assign rt_cnt = popcnt(rt_q);

`ifdef OPTIC_FLOW_DOMINANT_EN
  logic [CNT_W-1:0] dom_max;
  logic [1:0]       dom_dir;

  // Strict greater-than keeps the earlier direction on ties.
  always_comb begin
    dom_max = acc_up;
    dom_dir = 2'd0;
    if (acc_dn > dom_max) begin dom_max = acc_dn; dom_dir = 2'd1; end
    if (acc_lf > dom_max) begin dom_max = acc_lf; dom_dir = 2'd2; end
    if (acc_rt > dom_max) begin dom_max = acc_rt; dom_dir = 2'd3; end
  end
`endif

  always_comb begin
    ctl_res = '0;
    case (valueA[1:0])
      2'd0:    ctl_res = {16'(acc_up), 16'(acc_dn)};
      2'd1:    ctl_res = {16'(acc_lf), 16'(acc_rt)};
`ifdef OPTIC_FLOW_DOMINANT_EN
      2'd3:    ctl_res = {29'd0, |dom_max, dom_dir};
`endif
      default: ctl_res = '0;
    endcase
  end

  // Operand latch and mask register share the start edge so the count stage lands 2 cycles after start.
  always_ff @(posedge clock) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      up_q   <= '0;
      dn_q   <= '0;
      lf_q   <= '0;
      rt_q   <= '0;
      acc_up <= '0;
      acc_dn <= '0;
      acc_lf <= '0;
      acc_rt <= '0;
    end else begin
      done   <= 1'b0;
      result <= '0;
      if (busy) begin
        done   <= 1'b1;
        result <= {up_cnt, dn_cnt, lf_cnt, rt_cnt};
        acc_up <= sat_add(acc_up, up_cnt);
        acc_dn <= sat_add(acc_dn, dn_cnt);
        acc_lf <= sat_add(acc_lf, lf_cnt);
        acc_rt <= sat_add(acc_rt, rt_cnt);
        busy   <= 1'b0;
      end else if (start && ciN == CUSTOM_ID) begin
        up_q <= up_m;
        dn_q <= dn_m;
        lf_q <= lf_m;
        rt_q <= rt_m;
        busy <= 1'b1;
      end else if (start && ciN == CTRL_ID) begin
        done   <= 1'b1;
        result <= ctl_res;
        if (valueA[1:0] == 2'd2) begin
          acc_up <= '0;
          acc_dn <= '0;
          acc_lf <= '0;
          acc_rt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_optic_flow_accum_ci.sv
// Scoreboard bench: dut_a uses default parameters, dut_b uses CNT_W=8; both see identical stimulus.
module tb_optic_flow_accum_ci;

  localparam logic [7:0] CID  = 8'd30;
  localparam logic [7:0] CTRL = 8'd31;
`ifdef OPTIC_FLOW_DOMINANT_EN
  localparam logic [31:0] DOM_LEFT = 32'h6;
  localparam logic [31:0] DOM_UP   = 32'h4;
`else
  localparam logic [31:0] DOM_LEFT = 32'h0;
  localparam logic [31:0] DOM_UP   = 32'h0;
`endif

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done_a, done_b;
  logic [31:0] result_a, result_b;

  typedef struct {
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  optic_flow_accum_ci dut_a (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done_a), .result(result_a)
  );

  optic_flow_accum_ci #(.CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done_b), .result(result_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: every done pops one expectation; outside done both results must read 0.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done_a || done_b) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: done_a=%b done_b=%b, expected none", cyc, done_a, done_b);
        end else begin
          e = sb.pop_front();
          check("done_a", {31'd0, done_a}, 32'd1);
          check("done_b", {31'd0, done_b}, 32'd1);
          check("latency_cycle", cyc, e.cyc);
          check("result_a", result_a, e.exp_a);
          check("result_b", result_b, e.exp_b);
        end
      end else begin
        check("idle_result_a", result_a, 32'd0);
        check("idle_result_b", result_b, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] ci, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    ciN    = ci;
    valueA = a;
    valueB = b;
    step(1);
    start  = 1'b0;
    ciN    = 8'd0;
    valueA = '0;
    valueB = '0;
  endtask

  task automatic expect_done(input int lat, input logic [31:0] ea, input logic [31:0] eb);
    exp_t x;
    x.exp_a = ea;
    x.exp_b = eb;
    x.cyc   = cyc + lat;
    sb.push_back(x);
  endtask

  task automatic compute(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ea, input logic [31:0] eb);
    expect_done(2, ea, eb);
    pulse(CID, a, b);
    step(3);
  endtask

  task automatic ctl(input logic [1:0] op, input logic [31:0] ea, input logic [31:0] eb);
    expect_done(1, ea, eb);
    pulse(CTRL, {30'd0, op}, 32'd0);
    step(3);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    ciN    = 8'd0;
    valueA = '0;
    valueB = '0;
    step(3);
    check("reset_done_a", {31'd0, done_a}, 32'd0);
    check("reset_done_b", {31'd0, done_b}, 32'd0);
    check("reset_result_a", result_a, 32'd0);
    check("reset_result_b", result_b, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single up move, then read it back.
    compute(32'h0001_0000, 32'h0000_0001, 32'h0100_0000, 32'h0100_0000);
    ctl(2'd0, 32'h0001_0000, 32'h0001_0000);

    // Left move; right is blocked at column 0; no neighbour gives nothing.
    compute(32'h0001_0000, 32'h0002_0000, 32'h0000_0100, 32'h0000_0100);
    compute(32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

    // Foreign opcode ignored.
    pulse(8'd47, 32'hFFFF_0000, 32'h0000_FFFF);
    step(3);

    // Second left move with a start issued while busy that must be dropped.
    expect_done(2, 32'h0000_0100, 32'h0000_0100);
    pulse(CID, 32'h0001_0000, 32'h0002_0000);
    pulse(CID, 32'hFFFF_0000, 32'h0000_FFFF);
    step(3);
    ctl(2'd1, 32'h0002_0000, 32'h0002_0000);
    ctl(2'd0, 32'h0001_0000, 32'h0001_0000);

    // up=1, left=2: left dominates.
    ctl(2'd3, DOM_LEFT, DOM_LEFT);

    // Clear, then all-zero accumulators.
    ctl(2'd2, 32'h0, 32'h0);
    ctl(2'd0, 32'h0, 32'h0);
    ctl(2'd1, 32'h0, 32'h0);
    ctl(2'd3, 32'h0, 32'h0);

    // Saturation: 16 x 16 up moves = 256 (255 on the 8-bit build), then one more.
    for (int i = 0; i < 16; i++)
      compute(32'hFFFF_0000, 32'h0000_FFFF, 32'h1000_0000, 32'h1000_0000);
    ctl(2'd0, 32'h0100_0000, 32'h00FF_0000);
    ctl(2'd1, 32'h0, 32'h0);
    compute(32'hFFFF_0000, 32'h0000_FFFF, 32'h1000_0000, 32'h1000_0000);
    ctl(2'd0, 32'h0110_0000, 32'h00FF_0000);
    ctl(2'd2, 32'h0, 32'h0);
    ctl(2'd0, 32'h0, 32'h0);

    // Build up a nonzero state, then reset during stage 1 of a compute.
    compute(32'h0001_0000, 32'h0000_0001, 32'h0100_0000, 32'h0100_0000);
    pulse(CID, 32'h0001_0000, 32'h0002_0000);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    ctl(2'd0, 32'h0, 32'h0);
    compute(32'h0001_0000, 32'h0000_0001, 32'h0100_0000, 32'h0100_0000);
    ctl(2'd0, 32'h0001_0000, 32'h0001_0000);
    ctl(2'd3, DOM_UP, DOM_UP);

    // After a reset the dominant query reports nothing.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    ctl(2'd3, 32'h0, 32'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected done pulses never arrived, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
